// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan: extends a live BCD units digit to a 4-digit value and scans it
// onto a multiplexed 7-segment display with leading-zero blanking.
module bcd_disp_scan #(
    parameter int SCAN_DIV = 4,
    parameter bit LZB      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_in,
    input  logic       updown,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       wrap
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [3:0]    units_q, tens, hund, thou, tens_n, hund_n, thou_n, dig;
    logic          updown_q, carry, borrow, roll, last, blank;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    sel, sel_n;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign carry  = units_q == 4'd9 && bcd_in == 4'd0;
    assign borrow = units_q == 4'd0 && bcd_in == 4'd9;

    // 3-digit BCD increment/decrement of the upper digits; roll flags 999<->000
    always_comb begin
        tens_n = tens;
        hund_n = hund;
        thou_n = thou;
        roll   = 1'b0;
        if (carry) begin
            tens_n = tens == 4'd9 ? 4'd0 : tens + 4'd1;
            if (tens == 4'd9) begin
                hund_n = hund == 4'd9 ? 4'd0 : hund + 4'd1;
                if (hund == 4'd9) begin
                    thou_n = thou == 4'd9 ? 4'd0 : thou + 4'd1;
                    roll   = thou == 4'd9;
                end
            end
        end else if (borrow) begin
            tens_n = tens == 4'd0 ? 4'd9 : tens - 4'd1;
            if (tens == 4'd0) begin
                hund_n = hund == 4'd0 ? 4'd9 : hund - 4'd1;
                if (hund == 4'd0) begin
                    thou_n = thou == 4'd0 ? 4'd9 : thou - 4'd1;
                    roll   = thou == 4'd0;
                end
            end
        end
    end

    assign last  = scan_cnt == CW'(SCAN_DIV - 1);
    assign sel_n = last ? sel + 2'd1 : sel;
    assign dig   = sel_n == 2'd0 ? units_q : sel_n == 2'd1 ? tens : sel_n == 2'd2 ? hund : thou;
    assign blank = sel_n == 2'd0 ? units_q > 4'd9 :
                   LZB && thou == 4'd0 && (sel_n == 2'd3 || (hund == 4'd0 && (sel_n == 2'd2 || tens == 4'd0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            units_q  <= 4'd0;
            tens     <= 4'd0;
            hund     <= 4'd0;
            thou     <= 4'd0;
            updown_q <= 1'b1;
            scan_cnt <= '0;
            sel      <= 2'd0;
            seg      <= 7'h3F;
            an       <= 4'b0001;
            dp       <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            units_q  <= bcd_in;
            updown_q <= updown;
            tens     <= tens_n;
            hund     <= hund_n;
            thou     <= thou_n;
            wrap     <= wrap | roll;
            scan_cnt <= last ? '0 : scan_cnt + 1'b1;
            sel      <= sel_n;
            seg      <= blank ? 7'h00 : enc(dig);
            an       <= 4'b0001 << sel_n;
            dp       <= sel_n == 2'd0 && !updown_q;
        end
    end
endmodule

// File: tb/tb_bcd_disp_scan.sv
// tb_bcd_disp_scan: checks two display scanners (SCAN_DIV=4/LZB=1, SCAN_DIV=2/LZB=0)
// every cycle against a decimal-arithmetic model of the displayed value.
module tb_bcd_disp_scan;
    logic       clk = 1'b0, rst = 1'b1, updown = 1'b1;
    logic [3:0] bcd_in = 4'd7;
    logic [6:0] seg4, seg2;
    logic [3:0] an4, an2;
    logic       dp4, dp2, wrap4, wrap2;
    int         vec = 0, err = 0;
    int         m_units = 0, m_upper = 0, m_upd = 1, m_wrap = 0, m_k = 0;
    int         s_units = 0, s_upper = 0, s_upd = 1;
    bit         started = 1'b0;
    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_disp_scan #(.SCAN_DIV(4), .LZB(1'b1)) u4 (.clk(clk), .rst(rst), .bcd_in(bcd_in), .updown(updown),
        .seg(seg4), .an(an4), .dp(dp4), .wrap(wrap4));
    bcd_disp_scan #(.SCAN_DIV(2), .LZB(1'b0)) u2 (.clk(clk), .rst(rst), .bcd_in(bcd_in), .updown(updown),
        .seg(seg2), .an(an2), .dp(dp2), .wrap(wrap2));

    always #5 clk = ~clk;

    // Value model: upper three digits as an integer 0..999; display shows the pre-edge value
    initial forever begin
        @(posedge clk);
        started = 1'b1;
        if (rst) begin
            m_k = 0; m_units = 0; m_upper = 0; m_upd = 1; m_wrap = 0;
            s_units = 0; s_upper = 0; s_upd = 1;
        end else begin
            s_units = m_units; s_upper = m_upper; s_upd = m_upd;
            m_k++;
            if (m_units == 9 && bcd_in == 0) begin
                if (m_upper == 999) begin m_upper = 0; m_wrap = 1; end else m_upper++;
            end else if (m_units == 0 && bcd_in == 9) begin
                if (m_upper == 0) begin m_upper = 999; m_wrap = 1; end else m_upper--;
            end
            m_units = int'(bcd_in);
            m_upd = int'(updown);
        end
    end

    function automatic int esel(int sd);
        return (m_k / sd) % 4;
    endfunction

    function automatic logic [6:0] eseg(int sd, bit lzb);
        int s = esel(sd);
        int d, lim;
        if (s == 0) return s_units > 9 ? 7'h00 : tbl[s_units];
        d = s == 1 ? s_upper % 10 : s == 2 ? (s_upper / 10) % 10 : s_upper / 100;
        lim = s == 1 ? 1 : s == 2 ? 10 : 100;
        if (lzb && s_upper < lim) return 7'h00;
        return tbl[d];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("seg4", 32'(seg4), 32'(eseg(4, 1'b1)));
        chk("an4", 32'(an4), 32'(4'b0001 << esel(4)));
        chk("dp4", 32'(dp4), 32'(esel(4) == 0 && s_upd == 0));
        chk("wrap4", 32'(wrap4), 32'(m_wrap));
        chk("seg2", 32'(seg2), 32'(eseg(2, 1'b0)));
        chk("an2", 32'(an2), 32'(4'b0001 << esel(2)));
        chk("dp2", 32'(dp2), 32'(esel(2) == 0 && s_upd == 0));
        chk("wrap2", 32'(wrap2), 32'(m_wrap));
    end

    task automatic step(input logic r, input logic [3:0] b, input logic u, input int n);
        rst = r; bcd_in = b; updown = u;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(1, 7, 1, 2);
        chk("rst_seg", 32'(seg4), 32'h3F);
        chk("rst_an", 32'(an4), 32'h1);
        chk("rst_dp", 32'(dp4), 32'h0);
        chk("rst_wrap", 32'(wrap4), 32'h0);
        step(0, 7, 1, 2);
        chk("units7_seg", 32'(seg4), 32'h07);
        for (int i = 0; i <= 9; i++) step(0, 4'(i), 1, 1);
        step(0, 0, 1, 20);
        chk("carry_model", 32'(m_upper), 32'd1);
        step(0, 9, 0, 20);
        chk("borrow_model", 32'(m_upper), 32'd0);
        step(1, 0, 1, 1);
        for (int i = 0; i < 999; i++) begin
            step(0, 1, 1, 1); step(0, 9, 1, 1); step(0, 0, 1, 1);
        end
        chk("pre_roll_wrap", 32'(wrap4), 32'h0);
        chk("pre_roll_model", 32'(m_upper), 32'd999);
        step(0, 1, 1, 1); step(0, 9, 1, 1); step(0, 0, 1, 20);
        chk("roll_up_wrap", 32'(wrap4), 32'h1);
        step(0, 9, 0, 20);
        chk("roll_dn_model", 32'(m_upper), 32'd999);
        chk("roll_dn_wrap", 32'(wrap2), 32'h1);
        step(1, 9, 0, 1);
        chk("wrap_clr", 32'(wrap4), 32'h0);
        step(0, 1, 1, 4);
        chk("scan4_an", 32'(an4), 32'h2);
        chk("scan2_an", 32'(an2), 32'h4);
        step(0, 12, 1, 16);
        step(0, 9, 1, 2); step(0, 12, 1, 2); step(0, 0, 1, 16);
        chk("invalid_model", 32'(m_upper), 32'd0);
        step(0, 1, 1, 1); step(0, 9, 1, 2);
        step(1, 0, 1, 1); step(0, 0, 1, 16);
        chk("rst_nocarry", 32'(m_upper), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
